modulator_assemblage: RTL and testbench

- Digital carrier modulator for the DSP datapath.
- Takes a serial data bit `Din` and produces a 16-bit unsigned offset-binary sine sample every clock.
- `Mod` selects FSK, ASK, BPSK or QPSK; `Freq` selects one of four carrier frequencies.
- Output feeds a DAC or downstream DSP stage.

---
 rtl/modulator_assemblage.sv | 139 +++++++++++++
 tb/tb_modulator_assemblage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/modulator_assemblage.sv
// Carrier modulator: phase accumulator driving a quarter-wave sine ROM, with
// FSK/ASK/BPSK/QPSK keying and a free-running dibit framer for QPSK.
module modulator_assemblage #(
    parameter int WIDTH           = 16,
    parameter int PHASE_BITS      = 8,
    parameter int QPSK_BIT_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Din,
    input  logic [1:0]       Mod,
    input  logic [1:0]       Freq,
    output logic [WIDTH-1:0] out
);

    localparam int QUARTER  = 1 << (PHASE_BITS - 2);
    localparam int CNT_BITS = $clog2(QPSK_BIT_CYCLES);
    localparam real PI      = 3.14159265358979323846;
    localparam real AMPL    = real'((1 << (WIDTH - 1)) - 1);

    localparam logic [WIDTH-1:0]      MIDSCALE    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [PHASE_BITS-2:0] QUARTER_IDX = QUARTER[PHASE_BITS-2:0];
    localparam logic [CNT_BITS-1:0]   CNT_LAST    = CNT_BITS'(QPSK_BIT_CYCLES - 1);

    localparam logic [PHASE_BITS-1:0] OFS_HALF = PHASE_BITS'(2 * QUARTER);
    localparam logic [PHASE_BITS-1:0] OFS_00   = PHASE_BITS'(QUARTER / 2);
    localparam logic [PHASE_BITS-1:0] OFS_01   = PHASE_BITS'(3 * QUARTER / 2);
    localparam logic [PHASE_BITS-1:0] OFS_11   = PHASE_BITS'(5 * QUARTER / 2);
    localparam logic [PHASE_BITS-1:0] OFS_10   = PHASE_BITS'(7 * QUARTER / 2);

    localparam logic [1:0] MOD_FSK  = 2'b00;
    localparam logic [1:0] MOD_ASK  = 2'b01;
    localparam logic [1:0] MOD_BPSK = 2'b10;

    // Magnitude of the first quarter wave, entries 0..QUARTER inclusive.
    function automatic logic [WIDTH-1:0] quarter_amp(input int k);
        real angle;
        real mag;
        angle = 2.0 * PI * real'(k) / real'(1 << PHASE_BITS);
        mag   = AMPL * $sin(angle);
        return WIDTH'($rtoi(mag + 0.5));
    endfunction

    logic [WIDTH-1:0] amp_rom [0:QUARTER];

    generate
        for (genvar gi = 0; gi <= QUARTER; gi++) begin : g_rom
            assign amp_rom[gi] = quarter_amp(gi);
        end
    endgenerate

    logic [PHASE_BITS-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]      out_q, out_d;
    logic [CNT_BITS-1:0]   bit_cnt_q, bit_cnt_d;
    logic                  first_bit_q, first_bit_d;
    logic                  pair_flag_q, pair_flag_d;
    logic [1:0]            dibit_q, dibit_d;

    logic [PHASE_BITS-1:0] base_step;
    logic [PHASE_BITS-1:0] step;
    logic [PHASE_BITS-1:0] offset;
    logic                  amp_en;
    logic [PHASE_BITS-1:0] phase;
    logic [1:0]            quadrant;
    logic [PHASE_BITS-3:0] fine;
    logic [PHASE_BITS-2:0] rom_idx;
    logic [WIDTH-1:0]      amp;
    logic [WIDTH-1:0]      sample;

    always_comb begin
        base_step = PHASE_BITS'(1) << Freq;
        step      = base_step;
        offset    = '0;
        amp_en    = 1'b1;
        case (Mod)
            MOD_FSK:  if (Din) step = base_step << 1;
            MOD_ASK:  amp_en = Din;
            MOD_BPSK: if (!Din) offset = OFS_HALF;
            default: begin
                // Gray-coded constellation, one quadrant centre per dibit
                case (dibit_q)
                    2'b00:   offset = OFS_00;
                    2'b01:   offset = OFS_01;
                    2'b11:   offset = OFS_11;
                    default: offset = OFS_10;
                endcase
            end
        endcase
    end

    // Fold the 8-bit phase onto the quarter-wave table.
    assign phase    = acc_q + offset;
    assign quadrant = phase[PHASE_BITS-1:PHASE_BITS-2];
    assign fine     = phase[PHASE_BITS-3:0];
    assign rom_idx  = quadrant[0] ? (QUARTER_IDX - {1'b0, fine}) : {1'b0, fine};
    assign amp      = amp_rom[rom_idx];
    assign sample   = quadrant[1] ? (MIDSCALE - amp) : (MIDSCALE + amp);

    assign out_d = amp_en ? sample : MIDSCALE;
    assign acc_d = acc_q + step;

    always_comb begin
        bit_cnt_d   = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CNT_BITS'(1);
        first_bit_d = first_bit_q;
        pair_flag_d = pair_flag_q;
        dibit_d     = dibit_q;
        // Framer runs in every mode so switching into QPSK finds it in step.
        if (bit_cnt_q == CNT_LAST) begin
            if (!pair_flag_q) begin
                first_bit_d = Din;
                pair_flag_d = 1'b1;
            end else begin
                dibit_d     = {first_bit_q, Din};
                pair_flag_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_q       <= MIDSCALE;
            bit_cnt_q   <= '0;
            first_bit_q <= 1'b0;
            pair_flag_q <= 1'b0;
            dibit_q     <= 2'b00;
        end else begin
            acc_q       <= acc_d;
            out_q       <= out_d;
            bit_cnt_q   <= bit_cnt_d;
            first_bit_q <= first_bit_d;
            pair_flag_q <= pair_flag_d;
            dibit_q     <= dibit_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_modulator_assemblage.sv
// Bench for modulator_assemblage: directed scenarios, a per-cycle reference
// model built from the sine formula, and literal spot checks.
module tb_modulator_assemblage;

    logic        clk;
    logic        rst_n;
    logic        Din;
    logic [1:0]  Mod;
    logic [1:0]  Freq;
    logic [15:0] out;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    bit checking = 0;

    int m_acc = 0, m_out = 32768, m_cnt = 0, m_flag = 0, m_first = 0, m_dibit = 0;

    modulator_assemblage #(
        .WIDTH(16),
        .PHASE_BITS(8),
        .QPSK_BIT_CYCLES(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .Din(Din),
        .Mod(Mod),
        .Freq(Freq),
        .out(out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ref_lut(input int p);
        real s;
        s = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(p % 256) / 256.0);
        if (s >= 0.0) return 32768 + $rtoi(s + 0.5);
        else          return 32768 - $rtoi(-s + 0.5);
    endfunction

    // Reference model: what the spec says the next sample and phase must be.
    always @(posedge clk or negedge rst_n) begin
        int base, step, off, amp_on;
        if (!rst_n) begin
            m_acc = 0; m_out = 32768; m_cnt = 0;
            m_flag = 0; m_first = 0; m_dibit = 0;
        end else begin
            base = 1 << Freq;
            step = base; off = 0; amp_on = 1;
            case (Mod)
                2'd0: step = Din ? 2 * base : base;
                2'd1: amp_on = Din ? 1 : 0;
                2'd2: off = Din ? 0 : 128;
                default: begin
                    case (m_dibit)
                        0: off = 32;
                        1: off = 96;
                        3: off = 160;
                        default: off = 224;
                    endcase
                end
            endcase
            m_out = amp_on ? ref_lut((m_acc + off) % 256) : 32768;
            m_acc = (m_acc + step) % 256;
            if (m_cnt == 31) begin
                if (m_flag == 0) begin
                    m_first = Din ? 1 : 0;
                    m_flag  = 1;
                end else begin
                    m_dibit = 2 * m_first + (Din ? 1 : 0);
                    m_flag  = 0;
                end
            end
            m_cnt = (m_cnt + 1) % 32;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_n = 0;
        else        edge_n = edge_n + 1;
    end

    always @(negedge clk) begin
        if (checking) begin
            total = total + 1;
            if (out !== m_out[15:0]) begin
                bad = bad + 1;
                $display("FAIL model_cycle t=%0t edge=%0d mod=%0d got=%0d expected=%0d",
                         $time, edge_n, Mod, out, m_out);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total = total + 1;
        if (got != exp) begin
            bad = bad + 1;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_n, got, exp);
        end else begin
            $display("check %s edge=%0d out=%0d ok", name, edge_n, got);
        end
    endtask

    task automatic run_to(input int n);
        int guard;
        guard = 0;
        while (edge_n < n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (edge_n != n) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL run_to_timeout got=%0d expected=%0d", edge_n, n);
        end
    endtask

    task automatic do_reset(input logic [1:0] m, input logic [1:0] f, input logic d);
        @(negedge clk);
        #2;
        Mod = m; Freq = f; Din = d;
        rst_n = 1'b0;
        #1;
        check("reset_out", int'(out), 32768);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d", edge_n);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int mx, mn;
        rst_n = 1'b1; Din = 1'b0; Mod = 2'd0; Freq = 2'd0;
        #2 rst_n = 1'b0;
        #1 check("reset_async", int'(out), 32768);
        checking = 1;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset release, FSK Freq=00 Din=0
        do_reset(2'd0, 2'd0, 1'b0);
        run_to(1);   check("rst_e1", int'(out), 32768);
        run_to(65);  check("rst_e65", int'(out), 65535);
        run_to(193); check("rst_e193", int'(out), 1);

        // FSK mark tone
        do_reset(2'd0, 2'd0, 1'b1);
        run_to(33);  check("fsk_e33", int'(out), 65535);
        run_to(97);  check("fsk_e97", int'(out), 1);
        do_reset(2'd0, 2'd3, 1'b0);
        run_to(9);   check("fsk_f3_e9", int'(out), 65535);

        // ASK: silent for 300 clocks, then keyed on mid-phase
        do_reset(2'd1, 2'd1, 1'b0);
        run_to(300); check("ask_off", int'(out), 32768);
        Din = 1'b1;
        mx = 0; mn = 70000;
        repeat (128) begin
            @(negedge clk);
            if (edge_n == 301) check("ask_first", int'(out), ref_lut(88));
            if (int'(out) > mx) mx = int'(out);
            if (int'(out) < mn) mn = int'(out);
        end
        check("ask_max", mx, 65535);
        check("ask_min", mn, 1);

        // BPSK space then mark
        do_reset(2'd2, 2'd0, 1'b0);
        run_to(1);   check("bpsk_e1", int'(out), 32768);
        run_to(65);  check("bpsk_e65", int'(out), 1);
        Din = 1'b1;
        run_to(66);  check("bpsk_flip", int'(out), ref_lut(65));

        // QPSK held at 1
        do_reset(2'd3, 2'd0, 1'b1);
        run_to(1);   check("qpsk_e1", int'(out), 55938);
        run_to(64);  check("qpsk_e64", int'(out), ref_lut(95));
        run_to(65);  check("qpsk_e65", int'(out), 9598);

        // QPSK sequence 1,0 then 0,1
        do_reset(2'd3, 2'd0, 1'b1);
        run_to(32);  Din = 1'b0;
        run_to(65);  check("qseq_10", int'(out), 55938);
        run_to(96);  Din = 1'b1;
        run_to(129); check("qseq_01", int'(out), 9598);

        // Mode and frequency changes keep phase continuous
        Mod = 2'd2; Freq = 2'd2; Din = 1'b0;
        run_to(160);
        Mod = 2'd0; Freq = 2'd1; Din = 1'b1;
        run_to(200);
        Mod = 2'd3; Freq = 2'd3;
        run_to(300);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_midop", int'(out), 32768);
        @(negedge clk);
        Mod = 2'd3; Freq = 2'd0; Din = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_to(1);   check("post_reset_e1", int'(out), 55938);
        run_to(40);

        checking = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
